// File: rtl/dmem_arbiter_if.sv
// Bus bundle for dmem_arbiter: core and DMA request/return ports plus the
// single-port data memory side. The arbiter takes the slave view; the
// requesters and memory together take the master view.
interface dmem_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic          c_req;
  logic          c_we;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata;
  logic          c_gnt;
  logic          c_rvalid;
  logic [DW-1:0] c_rdata;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;

  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wr_dat;
  logic          rd_en;
  logic          wr_en;
  logic [DW-1:0] m_rd_dat;

  modport slave (
    input  c_req, c_we, c_addr, c_wdata, d_req, d_we, d_addr, d_wdata, m_rd_dat,
    output c_gnt, c_rvalid, c_rdata, d_gnt, d_rvalid, d_rdata,
    output m_addr, m_wr_dat, rd_en, wr_en
  );

  modport master (
    output c_req, c_we, c_addr, c_wdata, d_req, d_we, d_addr, d_wdata, m_rd_dat,
    input  c_gnt, c_rvalid, c_rdata, d_gnt, d_rvalid, d_rdata,
    input  m_addr, m_wr_dat, rd_en, wr_en
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: core port has fixed priority, DMA port gets one
// forced grant after waiting STARVE_MAX cycles. Read data is routed back to
// the issuing requester RD_LAT cycles after the read strobe.
// Optional performance counters are built when DMEM_ARB_PERF_CNT_EN is defined;
// otherwise the perf ports are tied to zero.
module dmem_arbiter #(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic                clk,
  input  logic                reset,
  dmem_arbiter_if.slave       bus,
  output logic [31:0]         perf_c_gnt,
  output logic [31:0]         perf_d_gnt,
  output logic [31:0]         perf_conflict
);

  typedef enum logic [0:0] {CorePri, DmaPri} pri_e;

  localparam logic [7:0] StarveMax = 8'(STARVE_MAX);

  pri_e              state_q, state_d;
  logic [7:0]        wait_q, wait_d;
  logic              d_gnt_q;
  logic              c_gnt, d_gnt;
  logic [RD_LAT-1:0] pv_q;  // return pipe: valid
  logic [RD_LAT-1:0] po_q;  // return pipe: owner (1 = DMA)
  logic              tail_v;

  // Grant selection and memory-side drive; everything is quiet during reset.
  always_comb begin
    c_gnt = 1'b0;
    d_gnt = 1'b0;
    if (!reset) begin
      if (state_q == DmaPri) begin
        d_gnt = bus.d_req;
        c_gnt = bus.c_req & ~bus.d_req;
      end else begin
        c_gnt = bus.c_req;
        d_gnt = bus.d_req & ~bus.c_req;
      end
    end
    bus.c_gnt    = c_gnt;
    bus.d_gnt    = d_gnt;
    bus.rd_en    = (c_gnt & ~bus.c_we) | (d_gnt & ~bus.d_we);
    bus.wr_en    = (c_gnt & bus.c_we) | (d_gnt & bus.d_we);
    bus.m_addr   = '0;
    bus.m_wr_dat = '0;
    if (c_gnt) begin
      bus.m_addr   = bus.c_addr;
      bus.m_wr_dat = bus.c_wdata;
    end else if (d_gnt) begin
      bus.m_addr   = bus.d_addr;
      bus.m_wr_dat = bus.d_wdata;
    end
  end

  // Starvation counter and priority next state.
  always_comb begin
    wait_d  = wait_q;
    state_d = state_q;
    // A request re-presented right after a DMA grant starts counting one cycle
    // later, so a fully contended bus rotates with a period of STARVE_MAX + 2.
    if (d_gnt) begin
      wait_d = 8'd0;
    end else if (bus.d_req && !d_gnt_q && (wait_q < StarveMax)) begin
      wait_d = 8'(wait_q + 8'd1);
    end
    unique case (state_q)
      CorePri: if (wait_d == StarveMax) state_d = DmaPri;
      DmaPri:  if (d_gnt) state_d = CorePri;
      default: state_d = CorePri;
    endcase
  end

  // Priority state, counter and read-return pipe registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CorePri;
      wait_q  <= 8'd0;
      d_gnt_q <= 1'b0;
      pv_q    <= '0;
      po_q    <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      d_gnt_q <= d_gnt;
      pv_q[0] <= bus.rd_en;
      po_q[0] <= d_gnt;
      for (int i = 1; i < int'(RD_LAT); i++) begin
        pv_q[i] <= pv_q[i-1];
        po_q[i] <= po_q[i-1];
      end
    end
  end

  // Route the returning word to the owner of the oldest outstanding read.
  always_comb begin
    tail_v       = pv_q[RD_LAT-1] & ~reset;
    bus.c_rvalid = tail_v & ~po_q[RD_LAT-1];
    bus.d_rvalid = tail_v & po_q[RD_LAT-1];
    bus.c_rdata  = bus.c_rvalid ? bus.m_rd_dat : '0;
    bus.d_rdata  = bus.d_rvalid ? bus.m_rd_dat : '0;
  end

`ifdef DMEM_ARB_PERF_CNT_EN
  logic [31:0] pc_q, pd_q, px_q;

  // Free-running wrap-around event counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= '0;
      pd_q <= '0;
      px_q <= '0;
    end else begin
      pc_q <= pc_q + 32'(c_gnt);
      pd_q <= pd_q + 32'(d_gnt);
      px_q <= px_q + 32'(bus.c_req & bus.d_req);
    end
  end

  // Hold the perf outputs at zero while reset is asserted.
  always_comb begin
    perf_c_gnt    = reset ? '0 : pc_q;
    perf_d_gnt    = reset ? '0 : pd_q;
    perf_conflict = reset ? '0 : px_q;
  end
`else
  assign perf_c_gnt    = '0;
  assign perf_d_gnt    = '0;
  assign perf_conflict = '0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter (RD_LAT=2, STARVE_MAX=8): directed
// scenarios followed by random two-port traffic against a reference model.
module tb_dmem_arbiter;
  localparam int unsigned RD_LAT     = 2;
  localparam int unsigned STARVE_MAX = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] perf_c_gnt, perf_d_gnt, perf_conflict;

  dmem_arbiter_if #(.AW(32), .DW(32)) bus ();

  dmem_arbiter #(.AW(32), .DW(32), .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus),
    .perf_c_gnt    (perf_c_gnt),
    .perf_d_gnt    (perf_d_gnt),
    .perf_conflict (perf_conflict)
  );

  always #5 clk = ~clk;

  // Memory device: writes land at the edge, read data appears RD_LAT cycles later.
  logic [31:0] tmem  [64];
  logic [31:0] rpipe [RD_LAT];
  always @(posedge clk) begin
    if (bus.wr_en) tmem[bus.m_addr[7:2]] <= bus.m_wr_dat;
    rpipe[0] <= tmem[bus.m_addr[7:2]];
    for (int i = 1; i < int'(RD_LAT); i++) rpipe[i] <= rpipe[i-1];
  end
  assign bus.m_rd_dat = rpipe[RD_LAT-1];

  int checks = 0;
  int failures = 0;

  // Requester state.
  logic        c_pend, c_pwe, d_pend, d_pwe;
  logic [31:0] c_paddr, c_pdata, d_paddr, d_pdata;
  bit          c_auto, d_auto, rnd_mode;

  // Reference model.
  typedef struct { bit own; logic [31:0] data; int due; } ret_t;
  ret_t        rq[$];
  logic [31:0] mmem [64];
  int          cyc, m_wait;
  bit          m_forced, m_skip;
  int unsigned p_c, p_d, p_x;

  // Last observed DUT values, for scenario-level checks.
  logic        obs_cg, obs_dg, obs_wr, obs_rd, obs_crv, obs_drv;
  logic [31:0] obs_crd, obs_drd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic new_c_req();
    c_pend = 1'b1; c_pwe = 1'($urandom_range(0, 1));
    c_paddr = 32'($urandom_range(0, 63)) << 2; c_pdata = $urandom;
  endtask

  task automatic new_d_req();
    d_pend = 1'b1; d_pwe = 1'($urandom_range(0, 1));
    d_paddr = 32'($urandom_range(0, 63)) << 2; d_pdata = $urandom;
  endtask

  task automatic set_c(input logic we, input logic [31:0] a, input logic [31:0] d);
    c_pend = 1'b1; c_pwe = we; c_paddr = a; c_pdata = d;
  endtask

  task automatic set_d(input logic we, input logic [31:0] a, input logic [31:0] d);
    d_pend = 1'b1; d_pwe = we; d_paddr = a; d_pdata = d;
  endtask

  task automatic model_reset();
    rq.delete();
    m_wait = 0; m_forced = 0; m_skip = 0;
    p_c = 0; p_d = 0; p_x = 0;
  endtask

  task automatic chk_perf(input string tag);
`ifdef DMEM_ARB_PERF_CNT_EN
    chk({tag, "_perf_c"}, perf_c_gnt, p_c);
    chk({tag, "_perf_d"}, perf_d_gnt, p_d);
    chk({tag, "_perf_x"}, perf_conflict, p_x);
`else
    chk({tag, "_perf_c"}, perf_c_gnt, 32'd0);
    chk({tag, "_perf_d"}, perf_d_gnt, 32'd0);
    chk({tag, "_perf_x"}, perf_conflict, 32'd0);
`endif
  endtask

  // One bus cycle: present requests, compare against the model, advance.
  task automatic cycle();
    logic        ecg, edg, erv_c, erv_d;
    logic [31:0] ea, ed, erd_c, erd_d;
    bus.c_req = c_pend; bus.c_we = c_pwe; bus.c_addr = c_paddr; bus.c_wdata = c_pdata;
    bus.d_req = d_pend; bus.d_we = d_pwe; bus.d_addr = d_paddr; bus.d_wdata = d_pdata;
    @(negedge clk);
    edg = d_pend && (m_forced || !c_pend);
    ecg = c_pend && !edg;
    ea = ecg ? c_paddr : (edg ? d_paddr : 32'd0);
    ed = ecg ? c_pdata : (edg ? d_pdata : 32'd0);
    erv_c = 0; erv_d = 0; erd_c = 0; erd_d = 0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      if (rq[0].own) begin erv_d = 1; erd_d = rq[0].data; end
      else begin erv_c = 1; erd_c = rq[0].data; end
      void'(rq.pop_front());
    end
    obs_cg = bus.c_gnt; obs_dg = bus.d_gnt; obs_wr = bus.wr_en; obs_rd = bus.rd_en;
    obs_crv = bus.c_rvalid; obs_drv = bus.d_rvalid; obs_crd = bus.c_rdata; obs_drd = bus.d_rdata;
    chk("c_gnt", bus.c_gnt, ecg);
    chk("d_gnt", bus.d_gnt, edg);
    chk("wr_en", bus.wr_en, (ecg && c_pwe) || (edg && d_pwe));
    chk("rd_en", bus.rd_en, (ecg && !c_pwe) || (edg && !d_pwe));
    chk("m_addr", bus.m_addr, ea);
    chk("m_wr_dat", bus.m_wr_dat, ed);
    chk("c_rvalid", bus.c_rvalid, erv_c);
    chk("c_rdata", bus.c_rdata, erd_c);
    chk("d_rvalid", bus.d_rvalid, erv_d);
    chk("d_rdata", bus.d_rdata, erd_d);
    // Model update.
    if (ecg || edg) begin
      if ((ecg && c_pwe) || (edg && d_pwe)) mmem[ea[7:2]] = ed;
      else rq.push_back('{own: edg, data: mmem[ea[7:2]], due: cyc + int'(RD_LAT)});
    end
    if (edg) begin
      m_wait = 0; m_forced = 0; m_skip = 1;
    end else begin
      if (d_pend && !m_skip && m_wait < int'(STARVE_MAX)) m_wait++;
      if (m_wait == int'(STARVE_MAX)) m_forced = 1;
      m_skip = 0;
    end
    p_c += 32'(ecg); p_d += 32'(edg); p_x += 32'(c_pend && d_pend);
    cyc++;
    @(posedge clk);
    #1;
    if (ecg) begin if (c_auto) new_c_req(); else c_pend = 0; end
    if (edg) begin if (d_auto) new_d_req(); else d_pend = 0; end
    if (rnd_mode && !c_pend && $urandom_range(0, 3) != 0) new_c_req();
    if (rnd_mode && !d_pend && $urandom_range(0, 1) != 0) new_d_req();
  endtask

  // Reset for n cycles; every output must be 0 while reset is held.
  task automatic do_reset(input int n);
    reset = 1'b1;
    bus.c_req = c_pend; bus.c_we = c_pwe; bus.c_addr = c_paddr; bus.c_wdata = c_pdata;
    bus.d_req = d_pend; bus.d_we = d_pwe; bus.d_addr = d_paddr; bus.d_wdata = d_pdata;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("rst_c_gnt", bus.c_gnt, 0);
      chk("rst_d_gnt", bus.d_gnt, 0);
      chk("rst_rd_en", bus.rd_en, 0);
      chk("rst_wr_en", bus.wr_en, 0);
      chk("rst_m_addr", bus.m_addr, 0);
      chk("rst_m_wr_dat", bus.m_wr_dat, 0);
      chk("rst_c_rvalid", bus.c_rvalid, 0);
      chk("rst_d_rvalid", bus.d_rvalid, 0);
      chk("rst_c_rdata", bus.c_rdata, 0);
      chk("rst_d_rdata", bus.d_rdata, 0);
      chk("rst_perf_c", perf_c_gnt, 0);
      chk("rst_perf_d", perf_d_gnt, 0);
      chk("rst_perf_x", perf_conflict, 0);
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin tmem[i] = '0; mmem[i] = '0; end
    c_pend = 0; c_pwe = 0; c_paddr = 0; c_pdata = 0;
    d_pend = 0; d_pwe = 0; d_paddr = 0; d_pdata = 0;
    c_auto = 0; d_auto = 0; rnd_mode = 0; cyc = 0;
    model_reset();
    c_pend = 1; d_pend = 1;  // requests present during reset must not be granted
    #1;
    do_reset(3);
    c_pend = 0; d_pend = 0;

    // 1: core write then core read of 0x10.
    set_c(1, 32'h10, 32'hDEADBEEF); cycle();
    chk("t1_wr_gnt", obs_cg, 1); chk("t1_wr_en", obs_wr, 1);
    set_c(0, 32'h10, 32'h0); cycle();
    chk("t1_rd_gnt", obs_cg, 1); chk("t1_rd_wr_en", obs_wr, 0);
    cycle(); chk("t1_early_rvalid", obs_crv, 0);
    cycle();
    chk("t1_rvalid", obs_crv, 1); chk("t1_rdata", obs_crd, 32'hDEADBEEF);
    chk("t1_d_rvalid", obs_drv, 0);

    // 2: DMA write then read of 0x20 with the core idle.
    set_d(1, 32'h20, 32'h1234); cycle(); chk("t2_wr_gnt", obs_dg, 1);
    set_d(0, 32'h20, 32'h0); cycle(); chk("t2_rd_gnt", obs_dg, 1);
    cycle(); cycle();
    chk("t2_rvalid", obs_drv, 1); chk("t2_rdata", obs_drd, 32'h1234);
    chk("t2_c_rvalid", obs_crv, 0); chk("t2_c_rdata", obs_crd, 0);

    // 4: preload, then back-to-back reads core@0, DMA@4, core@8.
    set_c(1, 32'h0, 32'hA0); cycle();
    set_c(1, 32'h4, 32'hA4); cycle();
    set_c(1, 32'h8, 32'hA8); cycle();
    set_c(0, 32'h0, 0); cycle();
    set_d(0, 32'h4, 0); cycle();
    set_c(0, 32'h8, 0); cycle();
    chk("t4_c0_rvalid", obs_crv, 1); chk("t4_c0_rdata", obs_crd, 32'hA0);
    cycle(); chk("t4_d4_rvalid", obs_drv, 1); chk("t4_d4_rdata", obs_drd, 32'hA4);
    chk("t4_d4_c_rvalid", obs_crv, 0);
    cycle(); chk("t4_c8_rvalid", obs_crv, 1); chk("t4_c8_rdata", obs_crd, 32'hA8);
    chk_perf("t4");

    // 5: starve DMA a little, issue a core read, then reset one cycle later.
    c_auto = 1; new_c_req(); set_d(0, 32'h4, 0);
    for (int i = 0; i < 3; i++) cycle();
    c_auto = 0; d_pend = 0;
    set_c(0, 32'h10, 0); cycle(); chk("t5_rd_gnt", obs_cg, 1);
    do_reset(1);
    for (int i = 0; i < 4; i++) begin cycle(); chk("t5_no_rvalid", obs_crv, 0); end

    // 3/6: both ports request every cycle; DMA wins on cycles 8 and 18.
    model_reset();
    do_reset(1);
    c_auto = 1; d_auto = 1; new_c_req(); new_d_req();
    for (int k = 0; k < 20; k++) begin
      cycle();
      chk("t3_d_gnt", obs_dg, (k % 10) == 8);
      chk("t3_c_gnt", obs_cg, (k % 10) != 8);
    end
`ifdef DMEM_ARB_PERF_CNT_EN
    chk("t6_perf_c", perf_c_gnt, 18);
    chk("t6_perf_d", perf_d_gnt, 2);
    chk("t6_perf_x", perf_conflict, 20);
`else
    chk("t6_perf_c", perf_c_gnt, 0);
    chk("t6_perf_d", perf_d_gnt, 0);
    chk("t6_perf_x", perf_conflict, 0);
`endif

    // Random traffic with a reset in the middle.
    c_auto = 0; d_auto = 0; rnd_mode = 1;
    for (int i = 0; i < 300; i++) cycle();
    do_reset(1);
    for (int i = 0; i < 300; i++) cycle();
    rnd_mode = 0;
    for (int i = 0; i < 2 * int'(STARVE_MAX) + 8; i++) cycle();
    chk("drain_c", c_pend, 0);
    chk("drain_d", d_pend, 0);
    chk_perf("rnd");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
